// File: rtl/sprite_pkg.sv
// Shared types and screen constants for the sprite movement controller.
package sprite_pkg;

    typedef enum logic [1:0] {IDLE, SAMPLE, UPDATE, COMMIT} move_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 11;

endpackage

// File: rtl/sprite_move_ctrl_btn_sync.sv
// N-bit two-flop synchroniser for asynchronous button inputs, cleared on reset.
module btn_sync #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);

    logic [N-1:0] sync_p0;
    logic [N-1:0] sync_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
        end
    end

    assign dout = sync_p1;

endmodule

// File: rtl/sprite_move_ctrl.sv
// Once-per-frame sprite origin stepper: samples buttons at vblank start and clamps to screen.
module sprite_move_ctrl
    import sprite_pkg::*;
#(
    parameter int H_ACTIVE  = SCREEN_W,
    parameter int V_ACTIVE  = SCREEN_H,
    parameter int SPR_W     = 32,
    parameter int SPR_H     = 16,
    parameter int INIT_X    = 304,
    parameter int INIT_Y    = 232,
    parameter int STEP      = 2,
    parameter int FRAME_DIV = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               enable,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_up,
    input  logic               btn_down,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               pos_valid
);

    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
    localparam logic [COORD_W:0] X_MAX  = (COORD_W + 1)'(H_ACTIVE - SPR_W);
    localparam logic [COORD_W:0] Y_MAX  = (COORD_W + 1)'(V_ACTIVE - SPR_H);
    localparam logic [COORD_W:0] STEP_W = (COORD_W + 1)'(STEP);

    move_state_t state, state_next;
    logic [3:0] btn_s;
    logic [3:0] btn_q;
    logic [CNT_W-1:0] frame_cnt;
    logic tick_cond, tick_cond_q, frame_tick;
    logic latch_btn, load_pos;
    logic [COORD_W:0] x_cur, y_cur, x_inc, y_inc;
    logic [COORD_W-1:0] nx, ny;

    btn_sync #(.N(4)) u_btn_sync (
        .clk  (clk),
        .reset(reset),
        .din  ({btn_left, btn_right, btn_up, btn_down}),
        .dout (btn_s)
    );

    // Single-cycle tick on the first cycle of vertical blanking.
    assign tick_cond = (pix_x == '0) && (pix_y == COORD_W'(V_ACTIVE));

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cond_q <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            tick_cond_q <= tick_cond;
            frame_tick  <= tick_cond & ~tick_cond_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_tick && enable) state_next = SAMPLE;
            SAMPLE:  state_next = (frame_cnt == CNT_LAST) ? UPDATE : IDLE;
            UPDATE:  state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        latch_btn = (state == SAMPLE);
        load_pos  = (state == UPDATE);
        pos_valid = (state == COMMIT);
    end

    // Clamp in one extra bit so a step past either edge can never wrap.
    assign x_cur = {1'b0, pos_x};
    assign y_cur = {1'b0, pos_y};
    assign x_inc = x_cur + STEP_W;
    assign y_inc = y_cur + STEP_W;

    always_comb begin
        nx = pos_x;
        ny = pos_y;
        if (btn_q[2] && !btn_q[3])
            nx = (x_inc > X_MAX) ? COORD_W'(X_MAX) : COORD_W'(x_inc);
        else if (btn_q[3] && !btn_q[2])
            nx = (x_cur < STEP_W) ? '0 : COORD_W'(x_cur - STEP_W);
        if (btn_q[0] && !btn_q[1])
            ny = (y_inc > Y_MAX) ? COORD_W'(Y_MAX) : COORD_W'(y_inc);
        else if (btn_q[1] && !btn_q[0])
            ny = (y_cur < STEP_W) ? '0 : COORD_W'(y_cur - STEP_W);
    end

    always_ff @(posedge clk) begin
        if (latch_btn) btn_q <= btn_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            pos_x     <= COORD_W'(INIT_X);
            pos_y     <= COORD_W'(INIT_Y);
        end else begin
            if (latch_btn)
                frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + 1'b1;
            if (load_pos) begin
                pos_x <= nx;
                pos_y <= ny;
            end
        end
    end

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// Directed bench for sprite_move_ctrl: default, edge-start and FRAME_DIV=3 instances.
module tb_sprite_move_ctrl;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    logic [10:0] pix_x, pix_y;
    logic enable, btn_left, btn_right, btn_up, btn_down;
    logic [10:0] pos_x_a, pos_y_a, pos_x_b, pos_y_b, pos_x_c, pos_y_c;
    logic pos_valid_a, pos_valid_b, pos_valid_c;

    int checks = 0;
    int errors = 0;
    int pa, pb, pc, lat_a;

    always #5 clk = ~clk;

    sprite_move_ctrl dut_a (
        .clk(clk), .reset(rst_a), .pix_x(pix_x), .pix_y(pix_y), .enable(enable),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .pos_x(pos_x_a), .pos_y(pos_y_a), .pos_valid(pos_valid_a)
    );

    sprite_move_ctrl #(.INIT_X(1), .INIT_Y(463)) dut_b (
        .clk(clk), .reset(rst_b), .pix_x(pix_x), .pix_y(pix_y), .enable(enable),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .pos_x(pos_x_b), .pos_y(pos_y_b), .pos_valid(pos_valid_b)
    );

    sprite_move_ctrl #(.FRAME_DIV(3)) dut_c (
        .clk(clk), .reset(rst_c), .pix_x(pix_x), .pix_y(pix_y), .enable(enable),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .pos_x(pos_x_c), .pos_y(pos_y_c), .pos_valid(pos_valid_c)
    );

    typedef struct {
        logic en, l, r, u, d;
        int   ex, ey, np;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_btn(input logic en, input logic l, input logic r,
                           input logic u, input logic d);
        @(negedge clk);
        enable = en; btn_left = l; btn_right = r; btn_up = u; btn_down = d;
        repeat (3) @(negedge clk);
    endtask

    // One vblank start; counts pos_valid pulses per instance over the following cycles.
    task automatic frame(input int drop_en, input int rst_at);
        pa = 0; pb = 0; pc = 0; lat_a = -1;
        pix_x = 11'd0; pix_y = 11'd480;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (pos_valid_a) begin
                pa++;
                if (lat_a < 0) lat_a = i;
            end
            if (pos_valid_b) pb++;
            if (pos_valid_c) pc++;
            if (i == 1) begin pix_x = 11'd5; pix_y = 11'd5; end
            if (i == drop_en) enable = 1'b0;
            if (i == rst_at) rst_a = 1'b1;
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 306, 232, 1};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 308, 232, 1};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 310, 232, 1};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 310, 232, 1};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 310, 230, 1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 310, 230, 0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 310, 230, 0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 310, 230, 1};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 308, 232, 1};

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        enable = 1'b1; btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        pix_x = 11'd5; pix_y = 11'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_pos_x", int'(pos_x_a), 304);
        chk("reset_pos_y", int'(pos_y_a), 232);
        chk("reset_valid", int'(pos_valid_a), 0);

        rst_a = 1'b0;
        pa = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (pos_valid_a) pa++;
        end
        chk("idle_no_valid", pa, 0);
        chk("idle_pos_x", int'(pos_x_a), 304);

        for (int k = 0; k < 9; k++) begin
            set_btn(tbl[k].en, tbl[k].l, tbl[k].r, tbl[k].u, tbl[k].d);
            frame(0, 0);
            chk($sformatf("vec%0d_x", k), int'(pos_x_a), tbl[k].ex);
            chk($sformatf("vec%0d_y", k), int'(pos_y_a), tbl[k].ey);
            chk($sformatf("vec%0d_pulses", k), pa, tbl[k].np);
            if (tbl[k].np > 0) chk($sformatf("vec%0d_latency", k), lat_a, 4);
        end

        // enable drops while the update is already in SAMPLE: it still lands
        set_btn(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        frame(2, 0);
        chk("endrop_pulses", pa, 1);
        chk("endrop_x", int'(pos_x_a), 310);
        enable = 1'b1;

        // reset during UPDATE abandons the step
        set_btn(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        frame(0, 3);
        chk("rst_upd_pulses", pa, 0);
        chk("rst_upd_x", int'(pos_x_a), 304);
        chk("rst_upd_y", int'(pos_y_a), 232);

        // start at (1,463): left/down clamps to (0,464) and stays there
        @(negedge clk);
        rst_b = 1'b0;
        set_btn(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 2; f++) begin
            frame(0, 0);
            chk($sformatf("clamp%0d_x", f), int'(pos_x_b), 0);
            chk($sformatf("clamp%0d_y", f), int'(pos_y_b), 464);
            chk($sformatf("clamp%0d_pulses", f), pb, 1);
        end
        rst_b = 1'b1;

        // FRAME_DIV=3: moves only on every third frame
        @(negedge clk);
        rst_c = 1'b0;
        set_btn(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int f = 1; f <= 6; f++) begin
            frame(0, 0);
            chk($sformatf("div%0d_y", f), int'(pos_y_c), (f < 3) ? 232 : (f < 6) ? 234 : 236);
            chk($sformatf("div%0d_pulses", f), pc, (f % 3 == 0) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
